// File: rtl/memory_access_unit.sv
// Single-outstanding load/store initiator for the 16-bit byte-addressed
// memory bus: request channel, memory handshake, byte-load extension, timeout.
module memory_access_unit #(
    parameter int TIMEOUT     = 64,
    parameter int ALIGN_CHECK = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic        ReqWidth,
    input  logic        ReqSigned,
    input  logic [15:0] ReqAddress,
    input  logic [15:0] ReqData,
    output logic        RespValid,
    output logic [15:0] RespData,
    output logic        RespError,
    output logic        MemReadEnable,
    output logic        MemWriteEnable,
    output logic        MemDataWidth,
    input  logic        MemReadReady,
    input  logic        MemWriteReady,
    input  logic [15:0] MemDataIn,
    output logic [15:0] MemDataOut,
    output logic [15:0] MemAddress
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic          en_read;
    logic          en_write;
    logic          sign_q;
    logic [CW-1:0] count;
    logic          misalign;
    logic          op_ready;
    logic          any_ready;
    logic          expired;
    logic [15:0]   load_data;

    assign misalign  = (ALIGN_CHECK != 0) && ReqWidth && ReqAddress[0];
    assign op_ready  = (en_read & MemReadReady) | (en_write & MemWriteReady);
    assign any_ready = MemReadReady | MemWriteReady;
    assign expired   = (TIMEOUT > 0) && (count == LAST);
    assign load_data = MemDataWidth ? MemDataIn :
                       {{8{sign_q & MemDataIn[7]}}, MemDataIn[7:0]};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (ReqValid && !misalign) next_state = ACCESS;
            end
            ACCESS: begin
                if (op_ready) next_state = IDLE;
                else if (expired) next_state = RECOVER;
            end
            RECOVER: begin
                if (any_ready || expired) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Masking by Ready keeps the responder from seeing a stale enable
    // in the cycle it completes.
    always_comb begin
        ReqReady       = (state == IDLE);
        MemReadEnable  = en_read & ~MemReadReady;
        MemWriteEnable = en_write & ~MemWriteReady;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            en_read      <= 1'b0;
            en_write     <= 1'b0;
            sign_q       <= 1'b0;
            count        <= '0;
            MemAddress   <= '0;
            MemDataOut   <= '0;
            MemDataWidth <= 1'b0;
            RespValid    <= 1'b0;
            RespError    <= 1'b0;
            RespData     <= '0;
        end else begin
            RespValid <= 1'b0;
            RespError <= 1'b0;
            RespData  <= '0;
            unique case (state)
                IDLE: begin
                    if (ReqValid && misalign) begin
                        RespValid <= 1'b1;
                        RespError <= 1'b1;
                    end else if (ReqValid) begin
                        MemAddress   <= ReqAddress;
                        MemDataOut   <= ReqData;
                        MemDataWidth <= ReqWidth;
                        sign_q       <= ReqSigned;
                        en_read      <= ~ReqWrite;
                        en_write     <= ReqWrite;
                        count        <= '0;
                    end
                end
                ACCESS: begin
                    if (op_ready) begin
                        en_read   <= 1'b0;
                        en_write  <= 1'b0;
                        RespValid <= 1'b1;
                        RespData  <= en_read ? load_data : 16'h0000;
                    end else if (expired) begin
                        en_read   <= 1'b0;
                        en_write  <= 1'b0;
                        RespValid <= 1'b1;
                        RespError <= 1'b1;
                        count     <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                RECOVER: begin
                    count <= count + 1'b1;
                end
                default: begin
                    en_read  <= 1'b0;
                    en_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: behavioural byte memory responder with
// programmable Ready delay, directed scenarios and randomized traffic.
module tb_memory_access_unit;

    localparam int TO = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic        ReqWidth;
    logic        ReqSigned;
    logic [15:0] ReqAddress;
    logic [15:0] ReqData;
    logic        RespValid;
    logic [15:0] RespData;
    logic        RespError;
    logic        MemReadEnable;
    logic        MemWriteEnable;
    logic        MemDataWidth;
    logic        MemReadReady;
    logic        MemWriteReady;
    logic [15:0] MemDataIn;
    logic [15:0] MemDataOut;
    logic [15:0] MemAddress;

    int tests = 0;
    int fails = 0;

    memory_access_unit #(.TIMEOUT(TO), .ALIGN_CHECK(1)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqWidth(ReqWidth), .ReqSigned(ReqSigned),
        .ReqAddress(ReqAddress), .ReqData(ReqData),
        .RespValid(RespValid), .RespData(RespData), .RespError(RespError),
        .MemReadEnable(MemReadEnable), .MemWriteEnable(MemWriteEnable),
        .MemDataWidth(MemDataWidth), .MemReadReady(MemReadReady),
        .MemWriteReady(MemWriteReady), .MemDataIn(MemDataIn),
        .MemDataOut(MemDataOut), .MemAddress(MemAddress)
    );

    always #5 Clock = ~Clock;

    // Byte-wide little-endian memory that completes D cycles after accept.
    logic [7:0]  mem [0:65535];
    logic        rsp_active;
    logic        rsp_write;
    int          rsp_cnt;
    int          rsp_dly;
    int          rsp_delay;
    logic        force_rd;
    logic        force_wr;
    logic        nat;
    logic [15:0] addr1;

    assign nat           = rsp_active && (rsp_cnt == rsp_dly);
    assign MemReadReady  = (nat && !rsp_write) || force_rd;
    assign MemWriteReady = (nat && rsp_write) || force_wr;
    assign addr1         = MemAddress + 16'd1;
    assign MemDataIn     = MemDataWidth ? {mem[addr1], mem[MemAddress]}
                                        : {8'h00, mem[MemAddress]};

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rsp_active <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_cnt    <= 0;
            rsp_dly    <= 0;
            for (int i = 0; i < 65536; i++) mem[i] <= 8'($urandom);
        end else begin
            if (nat) begin
                if (rsp_write) begin
                    mem[MemAddress] <= MemDataOut[7:0];
                    if (MemDataWidth) mem[addr1] <= MemDataOut[15:8];
                end
                rsp_active <= 1'b0;
            end else if (rsp_active && ((force_rd && !rsp_write) ||
                                        (force_wr && rsp_write))) begin
                rsp_active <= 1'b0;
            end else if (rsp_active) begin
                rsp_cnt <= rsp_cnt + 1;
            end
            if (ReqValid && ReqReady && !(ReqWidth && ReqAddress[0])) begin
                rsp_active <= 1'b1;
                rsp_write  <= ReqWrite;
                rsp_cnt    <= 0;
                rsp_dly    <= rsp_delay;
            end
        end
    end

    int   rd_spans = 0;
    int   wr_spans = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    always @(negedge Clock) begin
        if (MemReadEnable && !prev_rd) rd_spans = rd_spans + 1;
        if (MemWriteEnable && !prev_wr) wr_spans = wr_spans + 1;
        prev_rd = MemReadEnable;
        prev_wr = MemWriteEnable;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic run_req(input bit wr, input bit wd, input bit sg,
                           input logic [15:0] a, input logic [15:0] d,
                           input int dly, input bit foreign);
        bit          mis;
        bit          exp_err;
        logic [15:0] exp_data;
        logic [15:0] a_next;
        int          exp_lat;
        int          exp_span;
        int          lat;
        int          n;
        int          rs0;
        int          ws0;
        mis    = wd && a[0];
        a_next = a + 16'd1;
        if (mis) begin
            exp_err = 1'b1; exp_lat = 1;
        end else if (dly < TO) begin
            exp_err = 1'b0; exp_lat = dly + 2;
        end else begin
            exp_err = 1'b1; exp_lat = TO + 1;
        end
        if (exp_err || wr) exp_data = 16'h0000;
        else if (wd) exp_data = {mem[a_next], mem[a]};
        else exp_data = {{8{sg & mem[a][7]}}, mem[a]};
        exp_span = (mis || dly == 0) ? 0 : 1;
        rs0 = rd_spans;
        ws0 = wr_spans;
        rsp_delay  = dly;
        ReqWrite   = wr;
        ReqWidth   = wd;
        ReqSigned  = sg;
        ReqAddress = a;
        ReqData    = d;
        ReqValid   = 1'b1;
        tick();
        ReqValid = 1'b0;
        lat = 1;
        while (!RespValid && lat < 40) begin
            check("addr_hold", MemAddress, a);
            if (foreign && lat == 1) begin
                if (wr) force_rd = 1'b1;
                else force_wr = 1'b1;
            end
            tick();
            force_rd = 1'b0;
            force_wr = 1'b0;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("resp_error", RespError, exp_err);
        check("resp_data", RespData, exp_data);
        tick();
        check("resp_pulse", RespValid, 1'b0);
        n = 0;
        while (!ReqReady && n < 20) begin
            tick();
            n++;
        end
        check("ready_back", ReqReady, 1'b1);
        check("rd_spans", rd_spans - rs0, wr ? 0 : exp_span);
        check("wr_spans", wr_spans - ws0, wr ? exp_span : 0);
    endtask

    task automatic timeout_case(input bit wr, input bit late);
        int lat;
        int n;
        int rs0;
        int ws0;
        rs0 = rd_spans;
        ws0 = wr_spans;
        rsp_delay  = 999;
        ReqWrite   = wr;
        ReqWidth   = 1'b1;
        ReqSigned  = 1'b0;
        ReqAddress = 16'h0040;
        ReqData    = 16'h5A5A;
        ReqValid   = 1'b1;
        tick();
        ReqValid = 1'b0;
        lat = 1;
        while (!RespValid && lat < 40) begin
            tick();
            lat++;
        end
        check("to_latency", lat, TO + 1);
        check("to_error", RespError, 1'b1);
        check("to_data", RespData, 16'h0000);
        if (late) begin
            tick();
            check("recover_busy", ReqReady, 1'b0);
            if (wr) force_wr = 1'b1;
            else force_rd = 1'b1;
            tick();
            force_rd = 1'b0;
            force_wr = 1'b0;
            check("recover_exit", ReqReady, 1'b1);
            check("recover_noresp", RespValid, 1'b0);
        end else begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!ReqReady && n < 20);
            check("recover_len", n, TO);
            check("recover_noresp", RespValid, 1'b0);
        end
        check("to_rd_spans", rd_spans - rs0, wr ? 0 : 1);
        check("to_wr_spans", wr_spans - ws0, wr ? 1 : 0);
    endtask

    logic [15:0] b2b_addr [3];
    logic [15:0] b2b_exp [3];
    logic [15:0] ra;
    int          lat;
    int          rs0;
    int          k;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqWidth = 1'b0; ReqSigned = 1'b0;
        ReqAddress = '0; ReqData = '0;
        force_rd = 1'b0; force_wr = 1'b0; rsp_delay = 0;
        repeat (2) @(negedge Clock);
        check("rst_resp_valid", RespValid, 1'b0);
        check("rst_resp_data", RespData, 16'h0000);
        check("rst_resp_error", RespError, 1'b0);
        check("rst_rd_en", MemReadEnable, 1'b0);
        check("rst_wr_en", MemWriteEnable, 1'b0);
        check("rst_addr", MemAddress, 16'h0000);
        check("rst_dout", MemDataOut, 16'h0000);
        check("rst_width", MemDataWidth, 1'b0);
        Reset = 1'b1;
        tick();
        check("rst_req_ready", ReqReady, 1'b1);

        run_req(1, 0, 0, 16'h0010, 16'h0080, 0, 0);
        run_req(0, 0, 1, 16'h0010, 16'h0000, 0, 0);
        check("byte_signed_const", RespData, 16'h0000);
        run_req(0, 0, 0, 16'h0010, 16'h0000, 0, 0);
        run_req(1, 1, 0, 16'h0100, 16'hBEEF, 3, 0);
        run_req(0, 1, 0, 16'h0100, 16'h0000, 1, 0);
        run_req(0, 1, 0, 16'h0101, 16'h0000, 2, 0);
        run_req(0, 1, 0, 16'h0100, 16'h0000, 2, 1);
        run_req(1, 0, 0, 16'h0102, 16'h00C3, 2, 1);
        run_req(1, 1, 0, 16'hFFFE, 16'h1234, 1, 0);
        run_req(0, 1, 0, 16'hFFFE, 16'h0000, 0, 0);
        run_req(0, 0, 1, 16'hFFFF, 16'h0000, 1, 0);
        run_req(1, 1, 0, 16'hFFFF, 16'hAAAA, 1, 0);

        timeout_case(0, 1);
        timeout_case(1, 0);

        for (int i = 0; i < 3; i++) begin
            b2b_addr[i] = 16'(16'h0020 + 2 * i);
            ra = b2b_addr[i] + 16'd1;
            b2b_exp[i] = {mem[ra], mem[b2b_addr[i]]};
        end
        rs0 = rd_spans;
        rsp_delay  = 1;
        ReqWrite   = 1'b0;
        ReqWidth   = 1'b1;
        ReqSigned  = 1'b0;
        ReqAddress = b2b_addr[0];
        ReqValid   = 1'b1;
        tick();
        for (k = 0; k < 3; k++) begin
            lat = 1;
            while (!RespValid && lat < 10) begin
                tick();
                lat++;
            end
            check("b2b_latency", lat, 3);
            check("b2b_data", RespData, b2b_exp[k]);
            check("b2b_accept", ReqReady, 1'b1);
            if (k < 2) ReqAddress = b2b_addr[k+1];
            else ReqValid = 1'b0;
            tick();
        end
        check("b2b_pulse", RespValid, 1'b0);
        check("b2b_spans", rd_spans - rs0, 3);

        rsp_delay  = 5;
        ReqWrite   = 1'b0;
        ReqWidth   = 1'b1;
        ReqAddress = 16'h0030;
        ReqValid   = 1'b1;
        tick();
        ReqValid = 1'b0;
        check("mid_en_1", MemReadEnable, 1'b1);
        tick();
        check("mid_en_2", MemReadEnable, 1'b1);
        #2 Reset = 1'b0;
        #1 check("async_drop", MemReadEnable, 1'b0);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("rel_ready", ReqReady, 1'b1);
        check("rel_valid", RespValid, 1'b0);
        tick();
        check("rel_noresp", RespValid, 1'b0);

        for (int i = 0; i < 80; i++) begin
            bit          wr;
            bit          wd;
            bit          sg;
            bit          fg;
            logic [15:0] a;
            logic [15:0] d;
            int          r;
            int          dly;
            wr = 1'($urandom_range(0, 1));
            wd = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            fg = ($urandom_range(0, 3) == 0);
            r  = int'($urandom_range(0, 9));
            if (r == 0) a = 16'hFFFE + 16'($urandom_range(0, 1));
            else a = 16'(32 + $urandom_range(0, 31));
            d  = 16'($urandom);
            r  = int'($urandom_range(0, 9));
            dly = (r < 6) ? (r % 4) : ((r < 8) ? 5 : 999);
            run_req(wr, wd, sg, a, d, dly, fg);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
